// File: rtl/rv_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// rv_trace_buffer_if
// Event and readout bundle for rv_trace_buffer.
//   ev_valid/ev_kind/ev_pc/ev_target : one PC-redirect event per cycle from ID/EX
//   rd_valid/rd_ready/rd_data        : show-ahead ready/valid readout of the oldest entry
// Modports:
//   master : the pipeline/consumer side (drives events and rd_ready)
//   slave  : the trace buffer itself
// ---------------------------------------------------------------------------
interface rv_trace_buffer_if #(
   parameter int XLEN    = 32,
   parameter int ENTRY_W = 2 + 2 * XLEN
);
   logic               ev_valid;
   logic [1:0]         ev_kind;
   logic [XLEN-1:0]    ev_pc;
   logic [XLEN-1:0]    ev_target;
   logic               rd_valid;
   logic               rd_ready;
   logic [ENTRY_W-1:0] rd_data;

   modport master (
      output ev_valid, ev_kind, ev_pc, ev_target, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  ev_valid, ev_kind, ev_pc, ev_target, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/rv_trace_buffer.sv
// ---------------------------------------------------------------------------
// rv_trace_buffer
// Control-flow trace buffer: captures PC-redirect events into a circular
// buffer under a start / trigger / post-trigger capture state machine.
// Ports:
//   clock, reset (async, active-low)
//   start   : IDLE -> RUN pulse
//   clear   : return to IDLE, empty buffer, zero counters (beats start/events)
//   trig_en, trig_pc : PC-match trigger
//   bus     : rv_trace_buffer_if.slave (event input + show-ahead readout)
//   count   : number of stored entries
//   dropped : saturating count of lost (discarded or overwritten) events
//   state   : 0 IDLE, 1 RUN, 2 POST, 3 STOP
// Optional feature: define TRACE_TIMESTAMP_EN to prepend a TS_W-bit cycle
// stamp to each entry. Entry layout is {ts?, kind, pc, target}.
// ---------------------------------------------------------------------------
module rv_trace_buffer #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 16,
   parameter bit WRAP     = 1'b1,
   parameter int POST_CNT = 8,
   parameter bit REC_SEQ  = 1'b0,
   parameter int TS_W     = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       clear,
   input  logic                       trig_en,
   input  logic [XLEN-1:0]            trig_pc,
   rv_trace_buffer_if.slave           bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [15:0]                dropped,
   output logic [1:0]                 state
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef TRACE_TIMESTAMP_EN
   localparam int ENTRY_W = TS_W + 2 + 2 * XLEN;
`else
   localparam int ENTRY_W = 2 + 2 * XLEN;
`endif
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [7:0]       POST_LOAD = 8'(POST_CNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_POST = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [15:0]         dropped_q, dropped_d;
   logic [7:0]          post_q, post_d;
   logic [ENTRY_W-1:0]  mem_q [DEPTH];
   logic [ENTRY_W-1:0]  wr_entry;
   logic                empty, full, capturing, recordable, rec, pop, trig_hit;
   logic                wr_en, drop;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]     ts_q, ts_d;

   // Free-running cycle stamp; clear restarts it from zero.
   always_comb begin
      if (clear) begin
         ts_d = {TS_W{1'b0}};
      end else begin
         ts_d = ts_q + TS_W'(1);
      end
   end

   // Timestamp register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ts_q <= {TS_W{1'b0}};
      end else begin
         ts_q <= ts_d;
      end
   end

   assign wr_entry = {ts_q, bus.ev_kind, bus.ev_pc, bus.ev_target};
`else
   assign wr_entry = {bus.ev_kind, bus.ev_pc, bus.ev_target};
`endif

   assign empty      = (count_q == {CNT_W{1'b0}});
   assign full       = (count_q == CNT_FULL);
   assign capturing  = (state_q == ST_RUN) || (state_q == ST_POST);
   assign recordable = bus.ev_valid && ((bus.ev_kind != 2'd0) || REC_SEQ);
   assign rec        = recordable && capturing && !clear;
   assign pop        = !empty && bus.rd_ready && !clear;
   assign trig_hit   = rec && trig_en && (bus.ev_pc == trig_pc);

   // Buffer pointers, occupancy and loss counter.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      dropped_d = dropped_q;
      wr_en     = 1'b0;
      drop      = 1'b0;
      if (clear) begin
         head_d    = {PTR_W{1'b0}};
         tail_d    = {PTR_W{1'b0}};
         count_d   = {CNT_W{1'b0}};
         dropped_d = 16'd0;
      end else begin
         // A write into a full buffer with no pop is lost either way: in WRAP
         // mode the oldest entry is overwritten, otherwise the new one is discarded.
         wr_en = rec && (!full || pop || WRAP);
         drop  = rec && full && !pop;
         // When overwriting, tail equals head, so head must step past the victim.
         if (pop || (wr_en && full)) begin
            head_d = head_q + PTR_ONE;
         end else begin
            head_d = head_q;
         end
         if (wr_en) begin
            tail_d = tail_q + PTR_ONE;
         end else begin
            tail_d = tail_q;
         end
         if (wr_en && !full && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !wr_en) begin
            count_d = count_q - CNT_ONE;
         end else begin
            count_d = count_q;
         end
         if (drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
         end else begin
            dropped_d = dropped_q;
         end
      end
   end

   // Capture state machine: next state and post-trigger countdown.
   always_comb begin
      state_d = state_q;
      post_d  = post_q;
      if (clear) begin
         state_d = ST_IDLE;
         post_d  = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               // The trigger event is recorded under RUN rules and not counted in POST.
               if (trig_hit) begin
                  post_d = POST_LOAD;
                  if (POST_LOAD == 8'd0) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_POST;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_POST: begin
               // Discarded events (full, no wrap) still count toward the post window.
               if (rec) begin
                  post_d = post_q - 8'd1;
                  if (post_q == 8'd1) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_POST;
                  end
               end else begin
                  state_d = ST_POST;
               end
            end
            ST_STOP: begin
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         head_q    <= {PTR_W{1'b0}};
         tail_q    <= {PTR_W{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         dropped_q <= 16'd0;
         post_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         dropped_q <= dropped_d;
         post_q    <= post_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[tail_q] <= wr_entry;
      end
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_data  = empty ? {ENTRY_W{1'b0}} : mem_q[head_q];
   assign count        = count_q;
   assign dropped      = dropped_q;
   assign state        = state_q;
endmodule

// File: tb/tb_rv_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_rv_trace_buffer
// Two DEPTH=4 instances (WRAP=1 and WRAP=0) share one stimulus stream. A
// queue-based model of each buffer is advanced once per clock and compared
// with every DUT output on the falling edge. Directed scenarios pin the model
// with literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rv_trace_buffer;
   localparam int XLEN     = 32;
   localparam int DEPTH    = 4;
   localparam int POST_CNT = 2;
   localparam int TS_W     = 16;
`ifdef TRACE_TIMESTAMP_EN
   localparam int EW = TS_W + 2 + 2 * XLEN;
`else
   localparam int EW = 2 + 2 * XLEN;
`endif
   localparam int CW = $clog2(DEPTH + 1);
   localparam int S_IDLE = 0, S_RUN = 1, S_POST = 2, S_STOP = 3;

   typedef logic [EW-1:0] entry_t;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            start, clear, trig_en, ev_valid, rd_ready;
   logic [XLEN-1:0] trig_pc, ev_pc, ev_target;
   logic [1:0]      ev_kind;

   rv_trace_buffer_if #(.XLEN(XLEN), .ENTRY_W(EW)) bus_a ();
   rv_trace_buffer_if #(.XLEN(XLEN), .ENTRY_W(EW)) bus_b ();

   assign bus_a.ev_valid  = ev_valid;
   assign bus_a.ev_kind   = ev_kind;
   assign bus_a.ev_pc     = ev_pc;
   assign bus_a.ev_target = ev_target;
   assign bus_a.rd_ready  = rd_ready;
   assign bus_b.ev_valid  = ev_valid;
   assign bus_b.ev_kind   = ev_kind;
   assign bus_b.ev_pc     = ev_pc;
   assign bus_b.ev_target = ev_target;
   assign bus_b.rd_ready  = rd_ready;

   logic [CW-1:0] count_a, count_b;
   logic [15:0]   dropped_a, dropped_b;
   logic [1:0]    state_a, state_b;

   rv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP(1'b1), .POST_CNT(POST_CNT),
                     .REC_SEQ(1'b0), .TS_W(TS_W)) dut_a (
      .clock(clock), .reset(reset), .start(start), .clear(clear),
      .trig_en(trig_en), .trig_pc(trig_pc), .bus(bus_a),
      .count(count_a), .dropped(dropped_a), .state(state_a));

   rv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .WRAP(1'b0), .POST_CNT(POST_CNT),
                     .REC_SEQ(1'b0), .TS_W(TS_W)) dut_b (
      .clock(clock), .reset(reset), .start(start), .clear(clear),
      .trig_en(trig_en), .trig_pc(trig_pc), .bus(bus_b),
      .count(count_b), .dropped(dropped_b), .state(state_b));

   always #5 clock = ~clock;

   // DUT outputs gathered per instance (0 = WRAP, 1 = no WRAP).
   logic          o_valid [2];
   entry_t        o_data  [2];
   logic [CW-1:0] o_count [2];
   logic [15:0]   o_drop  [2];
   logic [1:0]    o_state [2];
   assign o_valid[0] = bus_a.rd_valid;  assign o_valid[1] = bus_b.rd_valid;
   assign o_data[0]  = bus_a.rd_data;   assign o_data[1]  = bus_b.rd_data;
   assign o_count[0] = count_a;         assign o_count[1] = count_b;
   assign o_drop[0]  = dropped_a;       assign o_drop[1]  = dropped_b;
   assign o_state[0] = state_a;         assign o_state[1] = state_b;

   // Behavioural model
   entry_t mq      [2][$];
   int     m_state [2];
   int     m_drop  [2];
   int     m_post  [2];
`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] m_ts;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [XLEN-1:0] t1_pc  [3] = '{32'h10, 32'h44, 32'h0C};
   logic [XLEN-1:0] t1_tgt [3] = '{32'h40, 32'h08, 32'h80};
   int              t5_st  [5] = '{S_RUN, S_POST, S_POST, S_STOP, S_STOP};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         m_state[i] = S_IDLE;
         m_drop[i]  = 0;
         m_post[i]  = 0;
      end
`ifdef TRACE_TIMESTAMP_EN
      m_ts = '0;
`endif
   endtask

   task automatic model_step();
      entry_t e;
      bit     recd, popd;
`ifdef TRACE_TIMESTAMP_EN
      e = {m_ts, ev_kind, ev_pc, ev_target};
`else
      e = {ev_kind, ev_pc, ev_target};
`endif
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            mq[i].delete();
            m_state[i] = S_IDLE;
            m_drop[i]  = 0;
            m_post[i]  = 0;
         end else begin
            popd = rd_ready && (mq[i].size() > 0);
            recd = ev_valid && (ev_kind != 2'd0) &&
                   (m_state[i] == S_RUN || m_state[i] == S_POST);
            if (popd) void'(mq[i].pop_front());
            if (recd) begin
               if (mq[i].size() < DEPTH) begin
                  mq[i].push_back(e);
               end else begin
                  if (i == 0) begin
                     void'(mq[i].pop_front());
                     mq[i].push_back(e);
                  end
                  if (m_drop[i] < 65535) m_drop[i]++;
               end
            end
            case (m_state[i])
               S_IDLE: if (start) m_state[i] = S_RUN;
               S_RUN: begin
                  if (recd && trig_en && ev_pc == trig_pc) begin
                     m_post[i]  = POST_CNT;
                     m_state[i] = (POST_CNT == 0) ? S_STOP : S_POST;
                  end
               end
               S_POST: begin
                  if (recd) begin
                     m_post[i]--;
                     if (m_post[i] == 0) m_state[i] = S_STOP;
                  end
               end
               default: ;
            endcase
         end
      end
`ifdef TRACE_TIMESTAMP_EN
      m_ts = clear ? '0 : m_ts + 1'b1;
`endif
   endtask

   task automatic check_all();
      entry_t exp_d;
      for (int i = 0; i < 2; i++) begin
         exp_d = (mq[i].size() > 0) ? mq[i][0] : '0;
         chk($sformatf("rd_valid[%0d]", i), 128'(o_valid[i]), 128'(mq[i].size() > 0));
         chk($sformatf("rd_data[%0d]", i), 128'(o_data[i]), 128'(exp_d));
         chk($sformatf("count[%0d]", i), 128'(o_count[i]), 128'(mq[i].size()));
         chk($sformatf("dropped[%0d]", i), 128'(o_drop[i]), 128'(m_drop[i]));
         chk($sformatf("state[%0d]", i), 128'(o_state[i]), 128'(m_state[i]));
      end
   endtask

   task automatic set_idle();
      start = 1'b0; clear = 1'b0; ev_valid = 1'b0; rd_ready = 1'b0;
      ev_kind = 2'd0; ev_pc = '0; ev_target = '0;
   endtask

   // One clock: model advances with the edge, outputs compared on the falling edge.
   task automatic cycle();
      model_step();
      @(posedge clock);
      @(negedge clock);
      check_all();
   endtask

   task automatic ev(input logic [1:0] k, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tg);
      ev_valid = 1'b1; ev_kind = k; ev_pc = pc; ev_target = tg;
      cycle();
      set_idle();
   endtask

   task automatic pulse_clear();
      clear = 1'b1; cycle(); set_idle();
   endtask

   task automatic pulse_start();
      start = 1'b1; cycle(); set_idle();
   endtask

   task automatic pop_one();
      rd_ready = 1'b1; cycle(); set_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_idle();
      trig_en = 1'b0;
      trig_pc = '0;
      model_reset();
      repeat (2) @(negedge clock);
      check_all();
      chk("reset_count", 128'(count_a), 128'd0);
      reset = 1'b1;

      // Three taken branches, popped back in order.
      pulse_start();
      for (int k = 0; k < 3; k++) ev(2'd1, t1_pc[k], t1_tgt[k]);
      chk("t1_count", 128'(count_a), 128'd3);
      chk("t1_dropped", 128'(dropped_a), 128'd0);
      for (int k = 0; k < 3; k++) begin
         chk("t1_kind", 128'(o_data[0][2*XLEN+1:2*XLEN]), 128'd1);
         chk("t1_pc", 128'(o_data[0][2*XLEN-1:XLEN]), 128'(t1_pc[k]));
         chk("t1_target", 128'(o_data[0][XLEN-1:0]), 128'(t1_tgt[k]));
         pop_one();
      end
      chk("t1_empty", 128'(count_a), 128'd0);

      // Six jumps into a 4-deep buffer: wrap vs. stop-when-full.
      pulse_clear();
      pulse_start();
      for (int k = 1; k <= 6; k++) ev(2'd3, 32'h100 + 32'h10 * k, 32'h1000 + k);
      chk("t2_count_wrap", 128'(count_a), 128'd4);
      chk("t2_head_wrap", 128'(o_data[0][2*XLEN-1:XLEN]), 128'h130);
      chk("t2_drop_wrap", 128'(dropped_a), 128'd2);
      chk("t3_count_stop", 128'(count_b), 128'd4);
      chk("t3_head_stop", 128'(o_data[1][2*XLEN-1:XLEN]), 128'h110);
      chk("t3_drop_stop", 128'(dropped_b), 128'd2);

      // Full buffer, event and pop together: no drop, new event lands at tail.
      rd_ready = 1'b1;
      ev(2'd3, 32'h170, 32'h2000);
      chk("t4_count", 128'(count_a), 128'd4);
      chk("t4_drop", 128'(dropped_a), 128'd2);
      chk("t4_head_wrap", 128'(o_data[0][2*XLEN-1:XLEN]), 128'h140);
      chk("t4_head_stop", 128'(o_data[1][2*XLEN-1:XLEN]), 128'h120);
      repeat (3) pop_one();
      chk("t4_tail_wrap", 128'(o_data[0][2*XLEN-1:XLEN]), 128'h170);
      chk("t4_tail_stop", 128'(o_data[1][2*XLEN-1:XLEN]), 128'h170);

      // Trigger at 0x24 with a two-event post window.
      pulse_clear();
      trig_en = 1'b1;
      trig_pc = 32'h24;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         ev(2'd1, 32'h20 + 32'h4 * k, 32'h900 + k);
         chk("t5_state", 128'(state_a), 128'(t5_st[k]));
      end
      chk("t5_count", 128'(count_b), 128'd4);
      chk("t5_dropped", 128'(dropped_a), 128'd0);

      // Asynchronous reset in the middle of POST.
      pulse_clear();
      pulse_start();
      ev(2'd1, 32'h24, 32'h50);
      chk("t6_post", 128'(state_a), 128'd2);
      #2 reset = 1'b0;
      #1;
      chk("t6_state", 128'(state_a), 128'd0);
      chk("t6_count", 128'(count_a), 128'd0);
      chk("t6_valid", 128'(bus_a.rd_valid), 128'd0);
      model_reset();
      @(negedge clock);
      check_all();
      reset = 1'b1;
      ev(2'd1, 32'h60, 32'h64);
      chk("t6_ignored", 128'(count_a), 128'd0);
      pulse_start();
      ev(2'd1, 32'h60, 32'h64);
      chk("t6_after_start", 128'(count_a), 128'd1);
      trig_en = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         start     = ($urandom_range(0, 15) == 0);
         clear     = ($urandom_range(0, 63) == 0);
         trig_en   = $urandom_range(0, 1) == 1;
         trig_pc   = 32'h20 + 32'h4 * $urandom_range(0, 3);
         ev_valid  = ($urandom_range(0, 3) != 0);
         ev_kind   = 2'($urandom_range(0, 3));
         ev_pc     = 32'h20 + 32'h4 * $urandom_range(0, 7);
         ev_target = $urandom;
         rd_ready  = ($urandom_range(0, 2) == 0);
         cycle();
      end
      set_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/rv_trace_buffer.md
# rv_trace_buffer

Synthesizable control-flow trace buffer for the RISC-V pipeline. It captures PC-redirect events (taken branches, jumps, and optionally sequential steps) reported by the ID/EX stage into a parametrised circular buffer. It supports a start/trigger/post-trigger capture state machine, selectable wrap or stop-when-full policy, and a ready/valid readout port, so the branch and PC history the simulation bench prints can also be recovered from silicon.

## Interface
- XLEN, 32, PC/target width.
- DEPTH, 16, entry count; power of two, ≥2.
- WRAP, 1, 1: overwrite oldest when full; 0: drop new events when full.
- POST_CNT, 8, events recorded after the trigger event before stopping; width 8 bits, 0 allowed.
- REC_SEQ, 0, 1: also record ev_kind=0 (sequential) events.
- TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  pulse: IDLE→RUN.
- clear  in  1  pulse: any state→IDLE, buffer emptied, counters zeroed.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  XLEN  trigger PC.
- ev_valid  in  1  event strobe, one per cycle max.
- ev_kind  in  2  0 sequential, 1 branch taken, 2 branch not taken, 3 jump.
- ev_pc  in  XLEN  PC of the instruction.
- ev_target  in  XLEN  next PC.
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  consumer pop.
- rd_data  out  ENTRY_W  head entry {ts?, kind, pc, target}; ENTRY_W = 2+2·XLEN (+TS_W).
- count  out  $clog2(DEPTH+1)  stored entries.
- dropped  out  16  saturating count of lost events (dropped or overwritten).
- state  out  2  0 IDLE, 1 RUN, 2 POST, 3 STOP.

## Operation
- Recordable event: ev_valid & (ev_kind≠0 | REC_SEQ). Recorded only in RUN or POST.
- IDLE: nothing recorded; start→RUN. start in other states ignored.
- RUN: record; trigger = trig_en & recordable & ev_pc==trig_pc → POST (POST_CNT>0) or STOP (POST_CNT=0). The trigger event itself is recorded and is not counted in POST.
- POST: post counter loads POST_CNT on entry and decrements per recorded (or dropped) event; reaching 0 → STOP. Further trigger matches are ignored.
- STOP: nothing recorded; readout continues; clear→IDLE.
- clear has priority over start and over every event in the same cycle.
- Full, WRAP=1, write without pop: the oldest entry is overwritten, head advances, count stays DEPTH, dropped+1.
- Full, WRAP=0, write without pop: event discarded, dropped+1; the state machine still counts it toward POST.
- Full with write and pop in the same cycle: pop oldest, append new, count unchanged, no drop.
- Empty with write and rd_ready in the same cycle: no pop; entry appears next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. dropped saturates at 16'hFFFF.

## Timing
- Reset values: state=IDLE, count=0, rd_valid=0, dropped=0, rd_data=0 (storage need not be reset, but rd_data is masked to 0 while empty), pointers=0, timestamp=0.
- Write latency: event at edge N is visible on rd_valid/rd_data/count after edge N.
- rd_data is combinational from the head (show-ahead); pop occurs at the edge where rd_valid & rd_ready.
- State transitions take effect at the edge sampling the cause. The event in the trigger cycle is recorded under RUN rules.
- Asynchronous reset mid-capture discards all contents immediately; the first record is possible only after a start pulse following reset release.

## Configuration
- TRACE_TIMESTAMP_EN defined: a free-running TS_W-bit cycle counter runs from reset and is zeroed by clear. It wraps silently, and its value at the write edge is prepended as rd_data MSBs.
- Not defined: no counter; ENTRY_W = 2+2·XLEN; TS_W is unused.

## Test plan
- Reset, start, 3 taken branches (pc 0x10→0x40, 0x44→0x08, 0x0C→0x80) → count=3; pops return them in order with kind=1; dropped=0.
- DEPTH=4, WRAP=1, 6 jumps → count=4, head holds event 3, dropped=2.
- DEPTH=4, WRAP=0, 6 jumps → count=4, head holds event 1, dropped=2.
- trig_pc=0x24, POST_CNT=2: events at 0x20, 0x24, 0x28, 0x2C, 0x30 → state RUN→POST→STOP after 0x2C, 4 entries stored, 0x30 absent.
- Full buffer, simultaneous event and pop → count unchanged, dropped unchanged, new event at the tail.
- Reset asserted mid-POST → state=IDLE, count=0, rd_valid=0 immediately; events are ignored until start.
